// File: rtl/lowpass_div_arbiter.sv
// rtl/lowpass_div_arbiter.sv - round-robin sharing of one pipelined divider among CH_NUM moving-average channels
// Optional feature macro: LP_ARB_ERR_CHECK_EN builds the ovf_flag_o / tag_err_o detection logic.
module lowpass_div_arbiter #(
    parameter int CH_NUM      = 4,
    parameter int DIV_LATENCY = 28,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         laser_start_i,
    input  logic [CH_NUM-1:0]            req_vld_i,
    input  logic [CH_NUM*24-1:0]         req_dividend_i,
    input  logic [CH_NUM*8-1:0]          req_divisor_i,
    output logic                         m_div_vld_o,
    output logic [23:0]                  m_div_dividend_o,
    output logic [7:0]                   m_div_divisor_o,
    input  logic                         s_div_vld_i,
    input  logic [31:0]                  s_div_data_i,
    output logic [CH_NUM-1:0]            lp_vld_o,
    output logic [CH_NUM*DATA_WIDTH-1:0] lp_data_o,
    output logic [CH_NUM-1:0]            ovf_flag_o,
    output logic                         tag_err_o
);
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    // Per-channel pending request holding registers
    logic [CH_NUM-1:0]            pend_q, pend_d;
    logic [CH_NUM-1:0][23:0]      dvd_q, dvd_d;
    logic [CH_NUM-1:0][7:0]       dsr_q, dsr_d;
    logic [CW-1:0]                ptr_q, ptr_d;

    // Registered divider issue stage, with the tag of the issuing channel
    logic                         m_vld_q, m_vld_d;
    logic [23:0]                  m_dvd_q, m_dvd_d;
    logic [7:0]                   m_dsr_q, m_dsr_d;
    logic [CW-1:0]                m_ch_q, m_ch_d;

    // Tag pipeline that mirrors the divider latency
    logic [DIV_LATENCY-1:0]           tag_vld_q, tag_vld_d;
    logic [DIV_LATENCY-1:0][CW-1:0]   tag_ch_q, tag_ch_d;
    logic                             tag_out_vld;
    logic [CW-1:0]                    tag_out_ch;

    // Result outputs
    logic [CH_NUM-1:0]                  lp_vld_q, lp_vld_d;
    logic [CH_NUM-1:0][DATA_WIDTH-1:0]  lp_data_q, lp_data_d;

    // Arbiter results
    logic [CH_NUM-1:0]            gnt_oh;
    logic [CW-1:0]                gnt_idx;
    logic [CW-1:0]                scan_idx;
    logic                         gnt_vld;

    // Only the quotient slice of the divider word is routed; the rest is ignored
    logic                         unused_div_bits;
    assign unused_div_bits = ^s_div_data_i;

    assign tag_out_vld = tag_vld_q[DIV_LATENCY-1];
    assign tag_out_ch  = tag_ch_q[DIV_LATENCY-1];

    // Round-robin search: the lowest offset from ptr_q with a pending request wins
    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            scan_idx = CW'((int'(ptr_q) + i) % CH_NUM);
            if (pend_q[scan_idx]) begin
                gnt_oh           = '0;
                gnt_oh[scan_idx] = 1'b1;
                gnt_idx          = scan_idx;
            end
        end
    end

    assign gnt_vld = |gnt_oh;

    // Pending register update and divider issue; a flush drops all pending work
    always_comb begin
        pend_d  = pend_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        ptr_d   = ptr_q;
        m_vld_d = 1'b0;
        m_dvd_d = m_dvd_q;
        m_dsr_d = m_dsr_q;
        m_ch_d  = m_ch_q;
        if (!laser_start_i) begin
            pend_d = '0;
        end else begin
            // A grant clears the bit, a same-edge request re-arms it with new data
            pend_d = pend_q & ~gnt_oh;
            for (int k = 0; k < CH_NUM; k++) begin
                if (req_vld_i[k]) begin
                    pend_d[k] = 1'b1;
                    dvd_d[k]  = req_dividend_i[24*k +: 24];
                    dsr_d[k]  = req_divisor_i[8*k +: 8];
                end
            end
            if (gnt_vld) begin
                m_vld_d = 1'b1;
                m_dvd_d = dvd_q[gnt_idx];
                // The divider cannot take a zero divisor; substitute 1
                m_dsr_d = (dsr_q[gnt_idx] == 8'd0) ? 8'd1 : dsr_q[gnt_idx];
                m_ch_d  = gnt_idx;
                ptr_d   = (gnt_idx == CW'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Tag shift and result routing back to the owning channel
    always_comb begin
        tag_vld_d[0] = m_vld_q;
        tag_ch_d[0]  = m_ch_q;
        for (int i = 1; i < DIV_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_ch_d[i]  = tag_ch_q[i-1];
        end
        lp_vld_d  = '0;
        lp_data_d = lp_data_q;
        if (!laser_start_i) begin
            tag_vld_d = '0;
        end else if (s_div_vld_i && tag_out_vld) begin
            lp_vld_d[tag_out_ch]  = 1'b1;
            lp_data_d[tag_out_ch] = s_div_data_i[8 +: DATA_WIDTH];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q    <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            ptr_q     <= '0;
            m_vld_q   <= 1'b0;
            m_dvd_q   <= '0;
            m_dsr_q   <= '0;
            m_ch_q    <= '0;
            tag_vld_q <= '0;
            tag_ch_q  <= '0;
            lp_vld_q  <= '0;
            lp_data_q <= '0;
        end else begin
            pend_q    <= pend_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            ptr_q     <= ptr_d;
            m_vld_q   <= m_vld_d;
            m_dvd_q   <= m_dvd_d;
            m_dsr_q   <= m_dsr_d;
            m_ch_q    <= m_ch_d;
            tag_vld_q <= tag_vld_d;
            tag_ch_q  <= tag_ch_d;
            lp_vld_q  <= lp_vld_d;
            lp_data_q <= lp_data_d;
        end
    end

    assign m_div_vld_o      = m_vld_q;
    assign m_div_dividend_o = m_dvd_q;
    assign m_div_divisor_o  = m_dsr_q;
    assign lp_vld_o         = lp_vld_q;
    assign lp_data_o        = lp_data_q;

`ifdef LP_ARB_ERR_CHECK_EN
    logic [CH_NUM-1:0] ovf_q, ovf_d;
    logic              tag_err_q, tag_err_d;

    // Sticky error detection; a flush holds the flags and suppresses new ones
    always_comb begin
        ovf_d     = ovf_q;
        tag_err_d = tag_err_q;
        if (laser_start_i) begin
            ovf_d = ovf_q | (req_vld_i & pend_q & ~gnt_oh);
            if (s_div_vld_i && !tag_out_vld) begin
                tag_err_d = 1'b1;
            end
        end
    end

    // Flag registers, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q     <= '0;
            tag_err_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            tag_err_q <= tag_err_d;
        end
    end

    assign ovf_flag_o = ovf_q;
    assign tag_err_o  = tag_err_q;
`else
    assign ovf_flag_o = '0;
    assign tag_err_o  = 1'b0;
`endif

endmodule

// File: doc/lowpass_div_arbiter.md
# lowpass_div_arbiter

Time-shares one pipelined `low_pass_divider` instance among `CH_NUM` moving-average channels of the PCG laser datapath. Each channel hands over one dividend/divisor pair per finished window sum. The block holds each request in a one-deep pending register and issues to the divider round-robin, at most one request per cycle. It tracks every in-flight operation with a channel tag pipeline and routes the 16-bit quotient back to the owning channel.

## Interface
Parameters:
- `CH_NUM`, 4: number of requesting channels (2..8).
- `DIV_LATENCY`, 28: fixed divider latency, from `m_div_vld_o` to `s_div_vld_i`, in cycles.
- `DATA_WIDTH`, 16: quotient width returned to channels.

Ports:
- `clk_i`  in  1  only clock. One clock; reset is synchronous and active-high.
- `rst_i`  in  1  synchronous, active-high reset.
- `laser_start_i`  in  1  scan enable; low flushes the block.
- `req_vld_i`  in  CH_NUM  per-channel request strobe.
- `req_dividend_i`  in  CH_NUM*24  channel k occupies bits [24k+23:24k].
- `req_divisor_i`  in  CH_NUM*8  channel k occupies bits [8k+7:8k].
- `m_div_vld_o`  out  1  divider input valid; drives both divisor and dividend tvalid.
- `m_div_dividend_o`  out  24  divider dividend.
- `m_div_divisor_o`  out  8  divider divisor.
- `s_div_vld_i`  in  1  divider `m_axis_dout_tvalid`.
- `s_div_data_i`  in  32  divider `m_axis_dout_tdata`.
- `lp_vld_o`  out  CH_NUM  per-channel result strobe.
- `lp_data_o`  out  CH_NUM*DATA_WIDTH  per-channel quotient.
- `ovf_flag_o`  out  CH_NUM  sticky per-channel request overflow.
- `tag_err_o`  out  1  sticky: divider result arrived with no matching tag.

## Operation
- Pending register per channel:
  - `req_vld_i[k]` loads that channel's dividend/divisor and sets `pend[k]`.
  - `pend[k]` clears when channel k is granted, unless a new request arrives on the same edge. In that case the new data is loaded and `pend[k]` stays 1.
- Overflow: `req_vld_i[k]` while `pend[k]`=1 and channel k is not granted that edge. The new data overwrites the held data and sets `ovf_flag_o[k]`.
- Arbiter: round-robin over `pend`.
  - The search starts at the channel after the last granted one.
  - After reset the pointer selects channel 0 as highest priority.
  - One grant per cycle whenever any `pend` bit is set.
  - No grant when no `pend` bit is set.
- Issue: on grant, the registered outputs load the channel's pair and `m_div_vld_o` goes to 1. A divisor of 0 is issued as 1.
- Tag pipeline: `DIV_LATENCY` stages, each holding {valid, channel index}, shifted every cycle and loaded from the issue.
- Return: when `s_div_vld_i`=1, the result is routed to the tagged channel.
  - `lp_data_o` slice receives `s_div_data_i[23:8]`.
  - The channel's `lp_vld_o` bit is a 1-cycle pulse.
  - `lp_data_o` holds its value between strobes.
- Tag error: `s_div_vld_i`=1 with the tag-pipeline output stage invalid. This sets `tag_err_o`; the result is dropped.
- `laser_start_i`=0 (registered, same priority as reset except for the flags):
  - Clears `pend`, the tag pipeline, `m_div_vld_o` and `lp_vld_o`.
  - Divider results returning while flushed are dropped silently; no `tag_err_o`.
  - Flags are held.
- Reset clears everything, including the flags.

## Timing
- Reset values: all outputs 0, round-robin pointer on channel 0.
- Uncontended latency:
  - Request sampled at edge 0.
  - `m_div_vld_o` high after edge 1.
  - Divider result after DIV_LATENCY more cycles.
  - `lp_vld_o` registered one edge later: DIV_LATENCY+2 edges after the request edge.
- Sustained throughput: one divide per cycle in total. Each channel's per-cycle request rate must stay ≤ 1/`CH_NUM`, otherwise `ovf_flag_o` fires.
- Worst-case wait from `pend` set to grant: `CH_NUM`-1 cycles.
- Divider is fully pipelined with no back-pressure; tready is unused.

## Configuration
- `LP_ARB_ERR_CHECK_EN`
  - Defined: `ovf_flag_o` and `tag_err_o` logic is built as specified.
  - Undefined: both outputs are tied to 0 and the detection logic is removed; routing, dropping and overwrite behaviour are unchanged.

## Test plan
- Single channel: `CH_NUM`=4, `DIV_LATENCY`=28. Channel 2 requests dividend 0x000F00, divisor 3; the divider model returns data[23:8]=0x0500 -> `lp_vld_o`=4'b0100 exactly 30 edges after the request, `lp_data_o[47:32]`=0x0500.
- Contention: all 4 channels request on the same edge -> issue order 0,1,2,3 on consecutive cycles; the next simultaneous burst issues 0,1,2,3 again. Each result arrives on its own channel, no flags.
- Overflow: channel 1 requests on two consecutive edges while channel 0 holds priority -> `ovf_flag_o[1]`=1, and only the second dividend is issued for channel 1.
- Divisor zero: channel 3 requests dividend 0x001234, divisor 0 -> `m_div_divisor_o`=1.
- Flush: `laser_start_i` dropped with 5 operations in flight -> no `lp_vld_o` pulses and `tag_err_o` stays 0. After `laser_start_i` returns, a new request completes normally.
- Tag error (macro defined): inject `s_div_vld_i` with an empty pipeline -> `tag_err_o`=1 and no `lp_vld_o`. With the macro undefined the same stimulus gives `tag_err_o`=0.
